// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: arbiter FSM state
// encodings and the byte width carried on every data path.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: starting at ptr_i and wrapping, selects
// the first asserted request and returns it as a one-hot grant and an index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  // Scan offsets from farthest to nearest so the request closest to ptr_i wins.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ
// byte producers. A granted byte is latched, a one-cycle tx_start is issued,
// and the frame is tracked through the rise and fall of tx_busy.
// Optional per-requester completed-frame counters are built when the macro
// UART_ARB_STATS_EN is defined; otherwise cnt_clr/frame_cnt do not exist.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      active,
  output logic [ID_W-1:0]           active_id,
  output logic                      frame_done
`ifdef UART_ARB_STATS_EN
  ,
  input  logic                      cnt_clr,
  output logic [NUM_REQ*CNT_W-1:0]  frame_cnt
`endif
);

  arb_state_e         state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [ID_W-1:0]    active_id_q;
  logic               tx_start_q;
  logic               active_q;
  logic               frame_done_q;
  logic [BYTE_W-1:0]  tx_data_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A grant is only offered in IDLE while the transmitter is free; a foreign
  // frame (busy seen in IDLE) blocks all grants.
  assign accept    = (state_q == ARB_IDLE) && !tx_busy && pick_any && !reset;
  assign req_ready = accept ? pick_gnt : '0;

  // Pointer moves one past the requester just served; with one requester it stays 0.
  assign rr_ptr_d = (active_id_q == ID_W'(NUM_REQ - 1)) ? '0 : active_id_q + 1'b1;

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign active     = active_q;
  assign active_id  = active_id_q;
  assign frame_done = frame_done_q;

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      active_id_q  <= '0;
      tx_start_q   <= 1'b0;
      active_q     <= 1'b0;
      frame_done_q <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            tx_data_q   <= req_data[int'(pick_idx)*BYTE_W +: BYTE_W];
            active_id_q <= pick_idx;
            active_q    <= 1'b1;
            tx_start_q  <= 1'b1;
            state_q     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          state_q <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          if (tx_busy) state_q <= ARB_WAIT_DONE;
        end
        ARB_WAIT_DONE: begin
          if (!tx_busy) begin
            state_q      <= ARB_IDLE;
            active_q     <= 1'b0;
            frame_done_q <= 1'b1;
            rr_ptr_q     <= rr_ptr_d;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef UART_ARB_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] frame_cnt_q;

  assign frame_cnt = frame_cnt_q;

  // Per-requester completed-frame counters; a clear overrides a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (cnt_clr) begin
      frame_cnt_q <= '0;
    end else if (frame_done_q) begin
      frame_cnt_q[int'(active_id_q)*CNT_W +: CNT_W] <=
        frame_cnt_q[int'(active_id_q)*CNT_W +: CNT_W] + 1'b1;
    end
  end
`else
  logic cnt_w_unused;
  assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx drives tx_busy and the
// serial line, a line decoder recovers transmitted bytes, and a queue-based
// round-robin model predicts grant order and data.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;
  localparam int BAUD  = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } grant_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*8-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             active;
  logic [ID_W-1:0]  active_id;
  logic             frame_done;
`ifdef UART_ARB_STATS_EN
  logic             cnt_clr;
  logic [N*CNT_W-1:0] frame_cnt;
`endif

  // behavioural transmitter state
  logic       force_busy;
  logic       u_busy, u_line, u_pend;
  logic [1:0] u_wait;
  int         u_cnt, u_bit;
  logic [9:0] u_shift;

  // requester queues (driven) and model copies (predicted)
  logic [7:0] rq[N][$];
  logic [7:0] mq[N][$];
  grant_t     gq[$];
  grant_t     eq[$];
  logic [7:0] rxq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int rdy_cycles = 0;
  int mptr = 0;
  logic       inflight = 1'b0;
  logic [N-1:0] acc = '0;
  logic [N-1:0] prev_acc = '0;
  logic [7:0] prev_data = 8'h00;
  logic       dec_busy = 1'b0;
  logic       line_prev = 1'b1;
  logic       dec_abort;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  assign tx_busy = u_busy | force_busy;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .active     (active),
    .active_id  (active_id),
    .frame_done (frame_done)
`ifdef UART_ARB_STATS_EN
    ,
    .cnt_clr    (cnt_clr),
    .frame_cnt  (frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_tx stand-in: busy rises at a random later baud pulse, then 10 bits at BAUD cycles each
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u_busy <= 1'b0; u_line <= 1'b1; u_pend <= 1'b0; u_wait <= 2'd0;
      u_cnt <= 0; u_bit <= 0; u_shift <= '1;
    end else if (u_pend) begin
      if (u_wait == 2'd0) begin
        u_pend <= 1'b0; u_busy <= 1'b1; u_line <= u_shift[0];
        u_bit <= 0; u_cnt <= BAUD - 1;
      end else begin
        u_wait <= u_wait - 2'd1;
      end
    end else if (u_busy) begin
      if (u_cnt == 0) begin
        if (u_bit == 9) begin
          u_busy <= 1'b0; u_line <= 1'b1;
        end else begin
          u_bit <= u_bit + 1; u_line <= u_shift[u_bit+1]; u_cnt <= BAUD - 1;
        end
      end else begin
        u_cnt <= u_cnt - 1;
      end
    end else if (tx_start) begin
      u_pend <= 1'b1;
      u_wait <= 2'($urandom_range(0, 3));
      u_shift <= {1'b1, tx_data, 1'b0};
    end
  end

  // serial line decoder: mid-bit sampling, frames touched by reset are dropped
  always begin
    @(negedge clk);
    if (!reset && line_prev && !u_line) begin
      dec_busy = 1'b1;
      dec_abort = 1'b0;
      repeat (BAUD/2) @(negedge clk);
      if (reset || u_line) dec_abort = 1'b1;
      for (int b = 0; b < 8; b++) begin
        repeat (BAUD) @(negedge clk);
        if (reset) dec_abort = 1'b1;
        rx_byte[b] = u_line;
      end
      repeat (BAUD) @(negedge clk);
      if (reset || !u_line) dec_abort = 1'b1;
      if (!dec_abort) rxq.push_back(rx_byte);
      dec_busy = 1'b0;
    end
    line_prev = u_line;
  end

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() > 0);
      req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endtask

  // requester driver and per-cycle protocol monitor
  always begin
    refresh();
    @(negedge clk);
    if (reset) begin
      inflight = 1'b0;
      prev_acc = '0;
      acc = '0;
    end else begin
      chk("start_after_accept", tx_start, (prev_acc != 0));
      if (tx_start) chk("tx_data_at_start", tx_data, prev_data);
      if (frame_done) begin
        fd_cnt++;
        chk("frame_done_inflight", inflight, 1'b1);
        inflight = 1'b0;
      end
      chk("ready_onehot0", $onehot0(req_ready), 1'b1);
      if (req_ready != 0) begin
        chk("ready_no_overlap", inflight, 1'b0);
        chk("ready_not_busy", tx_busy, 1'b0);
      end
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          rdy_cycles++;
          gq.push_back('{id: 2'(i), data: req_data[i*8 +: 8]});
          prev_data = req_data[i*8 +: 8];
          inflight = 1'b1;
        end
      end
      prev_acc = acc;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
    acc = '0;
  end

  task automatic load(input int i, input logic [7:0] b);
    rq[i].push_back(b);
    mq[i].push_back(b);
  endtask

  // reference: repeatedly serve the first non-empty queue at or after the pointer
  task automatic predict();
    bit found;
    int j;
    forever begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (!found && mq[j].size() > 0) begin
          eq.push_back('{id: 2'(j), data: mq[j].pop_front()});
          mptr = (j + 1) % N;
          found = 1'b1;
        end
      end
      if (!found) break;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    bit pending;
    c = 0;
    forever begin
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) pending = 1'b1;
      if (!pending && !active && !tx_busy && !u_pend && !dec_busy) break;
      if (c >= budget) break;
      @(negedge clk);
      c++;
    end
    n_tests++;
    assert (c < budget) else begin
      n_fail++;
      $error("FAIL %s_timeout observed=%0d cycles expected<%0d", tag, c, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_grant_count"}, gq.size(), eq.size());
    chk({tag, "_rx_count"}, rxq.size(), eq.size());
    for (int k = 0; k < eq.size(); k++) begin
      if (k < gq.size()) begin
        chk({tag, "_grant_id"}, gq[k].id, eq[k].id);
        chk({tag, "_grant_data"}, gq[k].data, eq[k].data);
      end
      if (k < rxq.size()) chk({tag, "_line_byte"}, rxq[k], eq[k].data);
    end
    gq.delete();
    eq.delete();
    rxq.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    mptr = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, tx_start, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_active"}, active, 1'b0);
    chk({tag, "_active_id"}, active_id, 2'd0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_req_ready"}, req_ready, 4'b0000);
  endtask

  initial begin
    int fd0;
    int k;
    reset = 1'b1;
    force_busy = 1'b0;
`ifdef UART_ARB_STATS_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // reset state with a request already pending
    load(2, 8'hA5);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
`ifdef UART_ARB_STATS_EN
    chk("reset_frame_cnt", frame_cnt[31:0], 32'h0);
`endif
    @(posedge clk); #3;
    reset = 1'b0;
    mptr = 0;

    // single requester
    predict();
    drain("single", 400);
    chk("single_fd", fd_cnt, 1);
    chk("single_ready_cycles", rdy_cycles, 1);
    chk("single_active_id", active_id, 2'd2);
    check_logs("single");

    // all four from a fresh pointer, then refill 0 and 3
    do_reset();
    for (int i = 0; i < N; i++) load(i, 8'h10 + 8'(i));
    predict();
    drain("all4", 800);
    check_logs("all4");
    load(0, 8'h20);
    load(3, 8'h23);
    predict();
    drain("refill", 600);
    check_logs("refill");

    // wrap: pointer at 3, only 0 and 1 pending
    load(2, 8'h30);
    predict();
    drain("wrap_pre", 400);
    check_logs("wrap_pre");
    load(0, 8'h40);
    load(1, 8'h41);
    predict();
    drain("wrap", 600);
    check_logs("wrap");

    // back-to-back on one requester
    fd0 = fd_cnt;
    load(1, 8'h01);
    load(1, 8'h02);
    load(1, 8'h03);
    predict();
    drain("b2b", 800);
    chk("b2b_fd", fd_cnt - fd0, 3);
    check_logs("b2b");

    // foreign frame holds off all grants
    @(posedge clk); #3;
    force_busy = 1'b1;
    load(3, 8'h55);
    repeat (20) @(negedge clk);
    chk("foreign_no_grant", gq.size(), 0);
    chk("foreign_idle", active, 1'b0);
    @(posedge clk); #3;
    force_busy = 1'b0;
    predict();
    drain("foreign", 400);
    check_logs("foreign");

    // randomized batches
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        k = $urandom_range(0, 2);
        for (int b = 0; b < k; b++) load(i, 8'($urandom));
      end
      predict();
      drain("random", 2000);
      check_logs("random");
    end

    // reset during WAIT_DONE aborts the frame, pending request served after release
    do_reset();
    load(0, 8'h66);
    predict();
    k = 0;
    while (!(active && u_busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_reached_busy", (k < 200), 1'b1);
    repeat (BAUD*3) @(negedge clk);
    fd0 = fd_cnt;
    load(2, 8'h77);
    @(posedge clk); #3;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (60) @(negedge clk);
    chk("midrst_no_fd", fd_cnt - fd0, 0);
    chk("midrst_rx_aborted", rxq.size(), 0);
    gq.delete();
    eq.delete();
    rxq.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    mptr = 0;
    predict();
    drain("midrst_after", 400);
    chk("midrst_after_fd", fd_cnt - fd0, 1);
    check_logs("midrst_after");

`ifdef UART_ARB_STATS_EN
    do_reset();
    for (int b = 0; b < 5; b++) load(0, 8'h80 + 8'(b));
    load(3, 8'hC0);
    load(3, 8'hC1);
    predict();
    drain("stats", 1500);
    check_logs("stats");
    chk("stats_cnt0", frame_cnt[0*CNT_W +: CNT_W], 16'd5);
    chk("stats_cnt1", frame_cnt[1*CNT_W +: CNT_W], 16'd0);
    chk("stats_cnt2", frame_cnt[2*CNT_W +: CNT_W], 16'd0);
    chk("stats_cnt3", frame_cnt[3*CNT_W +: CNT_W], 16'd2);
    @(posedge clk); #3;
    cnt_clr = 1'b1;
    @(posedge clk); #3;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr", frame_cnt, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
